// File: rtl/word_packer_if.sv
// Stream bundle for word_packer: narrow input beats in, packed words out.
// The slave modport is the packer's view; master is the view of whoever drives it.
interface word_packer_if #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = $clog2(RATIO + 1);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic             out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_last
    );
endinterface

// File: rtl/word_packer.sv
// Packs IN_W-bit beats into RATIO-lane words; in_last closes a partial word early.
// Lane order is selected by MSB_FIRST; unfilled lanes of a flushed word read as zero.
module word_packer #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    word_packer_if.slave bus
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = $clog2(RATIO + 1);

    logic [CW-1:0]    r_cnt;
    logic [OUT_W-1:0] r_acc;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic [CW-1:0]    r_out_count;
    logic             r_out_last;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_complete;
    logic [OUT_W-1:0] w_beat_word;

    // Place one beat into its lane of an otherwise-zero word.
    function automatic logic [OUT_W-1:0] lane_place(input logic [IN_W-1:0] beat,
                                                    input logic [CW-1:0]   lane);
        logic [OUT_W-1:0] word;
        word = '0;
        for (int n = 0; n < RATIO; n++) begin
            if (lane == CW'(n)) begin
                if (MSB_FIRST) word[OUT_W-1-n*IN_W -: IN_W] = beat;
                else           word[n*IN_W +: IN_W]         = beat;
            end
        end
        return word;
    endfunction

    assign w_in_ready  = en & (~r_out_valid | bus.out_ready);
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_complete  = w_accept & ((r_cnt == CW'(RATIO - 1)) | bus.in_last);
    assign w_beat_word = lane_place(bus.in_data, r_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_last  <= 1'b0;
        end else if (w_complete) begin
            // A completing beat refills the output even while it drains: no bubble.
            r_out_data  <= r_acc | w_beat_word;
            r_out_count <= r_cnt + CW'(1);
            r_out_last  <= bus.in_last;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_accept) begin
                r_acc <= r_acc | w_beat_word;
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
    assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_word_packer.sv
// Drives an MSB-first and an LSB-first packer with identical stimulus and compares
// both against a beat-queue reference model every cycle.
module tb_word_packer;
    localparam int IN_W  = 8;
    localparam int RATIO = 4;
    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = $clog2(RATIO + 1);

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    word_packer_if #(.IN_W(IN_W), .RATIO(RATIO)) bm ();
    word_packer_if #(.IN_W(IN_W), .RATIO(RATIO)) bl ();

    word_packer #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bm)
    );

    word_packer #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bl)
    );

    // Reference model state: beats gathered for the word in progress, plus the
    // word currently presented to the sink.
    logic [IN_W-1:0]  part[$];
    bit               m_have;
    logic [OUT_W-1:0] m_word_m;
    logic [OUT_W-1:0] m_word_l;
    logic [CW-1:0]    m_cnt;
    logic             m_last;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        part.delete();
        m_have   = 1'b0;
        m_word_m = '0;
        m_word_l = '0;
        m_cnt    = '0;
        m_last   = 1'b0;
    endtask

    // One clock: drive inputs, check everything observable, then advance the model.
    task automatic step(input bit v, input logic [IN_W-1:0] d, input bit l,
                        input bit ordy, input bit e, input bit r = 1'b0);
        bit exp_ready;
        bit acc;
        bm.in_valid = v;  bl.in_valid = v;
        bm.in_data  = d;  bl.in_data  = d;
        bm.in_last  = l;  bl.in_last  = l;
        bm.out_ready = ordy; bl.out_ready = ordy;
        en  = e;
        rst = r;
        #1;
        exp_ready = e & (!m_have | ordy);
        chk("in_ready_m",  bm.in_ready,  exp_ready);
        chk("in_ready_l",  bl.in_ready,  exp_ready);
        chk("out_valid_m", bm.out_valid, m_have);
        chk("out_valid_l", bl.out_valid, m_have);
        chk("out_data_m",  bm.out_data,  m_word_m);
        chk("out_data_l",  bl.out_data,  m_word_l);
        chk("out_count_m", bm.out_count, m_cnt);
        chk("out_count_l", bl.out_count, m_cnt);
        chk("out_last_m",  bm.out_last,  m_last);
        chk("out_last_l",  bl.out_last,  m_last);
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            acc = v & exp_ready;
            if (acc) part.push_back(d);
            if (acc && (part.size() == RATIO || l)) begin
                m_word_m = '0;
                m_word_l = '0;
                foreach (part[k]) begin
                    m_word_m |= OUT_W'(part[k]) << (IN_W * (RATIO - 1 - k));
                    m_word_l |= OUT_W'(part[k]) << (IN_W * k);
                end
                m_cnt  = CW'(part.size());
                m_last = l;
                m_have = 1'b1;
                part.delete();
            end else if (m_have && ordy) begin
                m_have = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bm.in_valid = 1'b0; bl.in_valid = 1'b0;
        bm.in_data  = '0;   bl.in_data  = '0;
        bm.in_last  = 1'b0; bl.in_last  = 1'b0;
        bm.out_ready = 1'b0; bl.out_ready = 1'b0;
        en  = 1'b1;
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, then four full-lane beats in both lane orders.
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h0F, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h0F, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h0F, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
        chk("t1_word_msb", bm.out_data, 32'h0F0F0F55);
        chk("t2_word_lsb", bl.out_data, 32'h550F0F0F);
        chk("t1_count",    bm.out_count, 3'd4);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Early flush with in_last on lane 1, then a word restarting at lane 0.
        step(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        chk("t3_word_msb", bm.out_data, 32'h3CA50000);
        chk("t3_word_lsb", bl.out_data, 32'h0000A53C);
        chk("t3_last",     bm.out_last, 1'b1);
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
        chk("t3_one_lane", bm.out_data, 32'h77000000);
        step(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h02, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h03, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h04, 1'b1, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Backpressure on a finished word, then release into a streaming burst.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
        chk("t4_word", bm.out_data, 32'h11223344);
        for (int i = 0; i < 5; i++) step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Enable low holds a partial word while in_valid stays high.
        step(1'b1, 8'hC1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'hC2, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'hC4, 1'b0, 1'b1, 1'b1);
        chk("t5_word", bm.out_data, 32'hC1C2C3C4);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Reset mid-word, and again while a word waits on the sink.
        step(1'b1, 8'hD1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'hD2, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'hD3, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b1, 1'b1);
        chk("t6_clean_word", bm.out_data, 32'hE0E1E2E3);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hF0 + i), 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6_valid_cleared", bm.out_valid, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
